data_writeback: RTL and testbench
=================================

DATA_WRITEBACK -- requirements
Module: data_writeback

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, port name reset.
REQ-002 SHALL define parameter CMD_WRITE, default 32'h0000000D, meaning the loading_state code that requests transmission of the buffered result.
REQ-003 SHALL define parameter ERR_CODE, default 32'h000000EE, meaning the loading_out_state value reported on failure.
REQ-004 SHALL define parameter TIMEOUT, default 16'hFFFF, meaning the maximum number of cycles to wait for dma_done.
REQ-005 SHALL have the following ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- result  in  1024  result word from the exponentiation core.
- result_valid  in  1  result is valid.
- result_ready  out  1  buffer can accept a result.
- loading_state  in  32  command word from the CPU.
- loading_out_state  out  32  acknowledge/status word to the CPU.
- dma_tx_data  out  1024  data presented to the DMA write channel.
- dma_tx_start  out  1  one-cycle DMA write start pulse.
- dma_done  in  1  DMA transfer complete.
- dma_idle  in  1  DMA ready to start a transfer.
- dma_error  in  1  DMA fault.
- busy  out  1  high in any state other than IDLE.
- tx_count  out  32  number of successful transfers.

Function
REQ-006 SHALL implement the FSM states IDLE, FULL, START, WAIT, DONE and ERROR; all state and output registers SHALL update on posedge clk.
REQ-007 IDLE: result_ready=1. If result_valid=1, the block SHALL capture result into the 1024-bit buffer and move to FULL on the next cycle.
REQ-008 result_ready SHALL be 0 in every state except IDLE; result_valid outside IDLE SHALL be ignored and SHALL NOT change the buffer.
REQ-009 FULL: when loading_state==CMD_WRITE and dma_idle=1, the block SHALL move to START; otherwise it SHALL hold.
REQ-010 START: dma_tx_start=1 for exactly one cycle, the timeout counter SHALL clear, and the next state SHALL be WAIT.
REQ-011 dma_tx_start SHALL be 0 in every state except START.
REQ-012 dma_tx_data SHALL always equal the buffer, and SHALL be stable from FULL through the exit from WAIT.
REQ-013 WAIT: the 16-bit timeout counter SHALL increment each cycle. Transitions:
- dma_done=1 -> DONE.
- dma_error=1 -> ERROR.
- counter==TIMEOUT -> ERROR.
- dma_error and dma_done in the same cycle -> ERROR (error wins).
REQ-014 On entry to DONE: loading_out_state <= CMD_WRITE and tx_count increments by 1; tx_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-015 DONE: when loading_state==0, the block SHALL go to IDLE and clear loading_out_state to 0; otherwise it SHALL hold.
REQ-016 On entry to ERROR: loading_out_state <= ERR_CODE and the buffer is discarded. When loading_state==0, the block SHALL go to IDLE with loading_out_state cleared to 0.
REQ-017 Pulses of dma_done or dma_error outside WAIT SHALL be ignored.
REQ-018 busy SHALL be a registered or state-decoded signal that is 1 in any state other than IDLE.

Reset
REQ-019 When reset=1 at posedge clk, the block SHALL force:
- state=IDLE, buffer=0, loading_out_state=0.
- tx_count=0, timeout counter=0.
- dma_tx_start=0, busy=0; result_ready=1 in the following cycle.
REQ-020 Reset asserted mid-transfer (START or WAIT) SHALL abort the transfer without a further dma_tx_start pulse and SHALL take priority over all other inputs.

Structure
REQ-021 The state enumeration, CMD_WRITE, ERR_CODE and the 1024-bit width constant SHALL reside in the shared RSA package, also used by data_preparation-side logic.
REQ-022 The timeout counter SHALL be a separate sub-module, wb_timeout_counter, with clear, enable, and a terminal-count flag output.
REQ-023 The whole block SHALL be implemented as a single FSM plus datapath registers; no further sub-modules are required.

Verification
REQ-024 Nominal transfer: result=1024'hA5…A5 with valid for 1 cycle, then loading_state=0x0D with dma_idle=1, then dma_done 10 cycles after the start pulse -> exactly one dma_tx_start pulse, dma_tx_data=A5…A5, loading_out_state=0x0D, tx_count=1; after loading_state=0: IDLE with out_state=0.
REQ-025 Back-pressure: a second result_valid with 1024'h1 while in FULL -> buffer unchanged, result_ready=0.
REQ-026 DMA error: dma_error=1 during WAIT -> loading_out_state=0xEE, tx_count unchanged; after loading_state=0 -> IDLE.
REQ-027 Timeout: dma_done never arrives -> ERROR entered 65536 cycles after START (±1 cycle, exact value per implementation note), out_state=0xEE.
REQ-028 Simultaneous dma_done and dma_error in WAIT -> ERROR; reset pulse in WAIT -> IDLE, tx_count=0, no dma_tx_start.
REQ-029 Not busy: dma_idle=0 in FULL with the command present -> no start pulse until dma_idle rises, then start follows on the next cycle.

Source files
------------

// File: rtl/data_writeback_pkg.sv
// data_writeback_pkg: shared RSA constants, state codes and word type for the writeback path
package data_writeback_pkg;
  localparam int DATA_W = 1024;
  typedef logic [DATA_W-1:0] word_t;
  localparam logic [31:0] CMD_WRITE_DEF = 32'h0000000D;
  localparam logic [31:0] ERR_CODE_DEF = 32'h000000EE;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FULL = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
endpackage

// File: rtl/data_writeback_timeout_counter.sv
// wb_timeout_counter: 16-bit cycle counter with clear, enable and terminal-count flag
module wb_timeout_counter #(
  parameter logic [15:0] MAX = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : en ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tc = cnt_q == MAX;
endmodule

// File: rtl/data_writeback.sv
// data_writeback: buffers one exponentiation result and hands it to the DMA write channel on CPU command
module data_writeback import data_writeback_pkg::*; #(
  parameter logic [31:0] CMD_WRITE = CMD_WRITE_DEF,
  parameter logic [31:0] ERR_CODE = ERR_CODE_DEF,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  word_t       result,
  input  logic        result_valid,
  output logic        result_ready,
  input  logic [31:0] loading_state,
  output logic [31:0] loading_out_state,
  output word_t       dma_tx_data,
  output logic        dma_tx_start,
  input  logic        dma_done,
  input  logic        dma_idle,
  input  logic        dma_error,
  output logic        busy,
  output logic [31:0] tx_count
);
  logic [2:0]  state_q, state_d;
  word_t       buf_q, buf_d;
  logic [31:0] out_q, out_d;
  logic [31:0] tx_count_q, tx_count_d;
  logic        tc;
  wb_timeout_counter #(.MAX(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst(reset),
    .clear(state_q == S_START),
    .en(state_q == S_WAIT),
    .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    out_d = out_q;
    tx_count_d = tx_count_q;
    case (state_q)
      S_IDLE: if (result_valid) begin
        buf_d = result;
        state_d = S_FULL;
      end
      S_FULL: if (loading_state == CMD_WRITE && dma_idle) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: if (dma_error || tc) begin
        state_d = S_ERROR;
        out_d = ERR_CODE;
        buf_d = '0;
      end else if (dma_done) begin
        state_d = S_DONE;
        out_d = CMD_WRITE;
        tx_count_d = tx_count_q + 32'd1;
      end
      S_DONE, S_ERROR: if (loading_state == 32'd0) begin
        state_d = S_IDLE;
        out_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q <= '0;
      out_q <= '0;
      tx_count_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      out_q <= out_d;
      tx_count_q <= tx_count_d;
    end
  end
  assign result_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign dma_tx_start = state_q == S_START;
  assign dma_tx_data = buf_q;
  assign loading_out_state = out_q;
  assign tx_count = tx_count_q;
endmodule

// File: tb/tb_data_writeback.sv
// tb_data_writeback: directed scenario tasks for data_writeback with inline checks
module tb_data_writeback;
  logic           clk = 0;
  logic           reset = 1;
  logic [1023:0]  result = '0;
  logic           result_valid = 0;
  logic           result_ready;
  logic [31:0]    loading_state = '0;
  logic [31:0]    loading_out_state;
  logic [1023:0]  dma_tx_data;
  logic           dma_tx_start;
  logic           dma_done = 0;
  logic           dma_idle = 0;
  logic           dma_error = 0;
  logic           busy;
  logic [31:0]    tx_count;
  int total = 0;
  int bad = 0;
  int starts = 0;
  logic [1023:0] pat_a5, pat_one, pat_3c;

  data_writeback dut (
    .clk(clk), .reset(reset), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .loading_state(loading_state),
    .loading_out_state(loading_out_state), .dma_tx_data(dma_tx_data),
    .dma_tx_start(dma_tx_start), .dma_done(dma_done), .dma_idle(dma_idle),
    .dma_error(dma_error), .busy(busy), .tx_count(tx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (dma_tx_start) starts++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic to_wait(input logic [1023:0] d);
    result = d;
    result_valid = 1;
    tick();
    result_valid = 0;
    loading_state = 32'h0D;
    dma_idle = 1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    reset = 1;
    tick();
    tick();
    reset = 0;
    total += 6;
    if (result_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", result_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (loading_out_state !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", loading_out_state); end
    if (tx_count !== 32'h0) begin bad++; $display("FAIL reset_txcount got=%0d exp=0", tx_count); end
    if (dma_tx_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", dma_tx_data[63:0]); end
    if (dma_tx_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", dma_tx_start); end
  endtask

  task automatic test_nominal;
    int s0;
    s0 = starts;
    result = pat_a5;
    result_valid = 1;
    tick();
    result_valid = 0;
    total += 3;
    if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b exp=1", busy); end
    if (result_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", result_ready); end
    if (dma_tx_data !== pat_a5) begin bad++; $display("FAIL full_data got=%h exp=%h", dma_tx_data[63:0], pat_a5[63:0]); end
    result = pat_one;
    result_valid = 1;
    tick();
    tick();
    result_valid = 0;
    total += 3;
    if (dma_tx_data !== pat_a5) begin bad++; $display("FAIL backpressure_data got=%h exp=%h", dma_tx_data[63:0], pat_a5[63:0]); end
    if (result_ready !== 1'b0) begin bad++; $display("FAIL backpressure_ready got=%b exp=0", result_ready); end
    if (starts != s0) begin bad++; $display("FAIL nocmd_start got=%0d exp=%0d", starts - s0, 0); end
    loading_state = 32'h0D;
    dma_idle = 1;
    tick();
    total += 1;
    if (dma_tx_start !== 1'b1) begin bad++; $display("FAIL start_pulse got=%b exp=1", dma_tx_start); end
    for (int i = 0; i < 10; i++) tick();
    dma_done = 1;
    tick();
    dma_done = 0;
    total += 5;
    if (loading_out_state !== 32'h0D) begin bad++; $display("FAIL done_out got=%h exp=0000000d", loading_out_state); end
    if (tx_count !== 32'd1) begin bad++; $display("FAIL done_txcount got=%0d exp=1", tx_count); end
    if (starts - s0 != 1) begin bad++; $display("FAIL nominal_starts got=%0d exp=1", starts - s0); end
    if (dma_tx_data !== pat_a5) begin bad++; $display("FAIL done_data got=%h exp=%h", dma_tx_data[63:0], pat_a5[63:0]); end
    if (busy !== 1'b1) begin bad++; $display("FAIL done_busy got=%b exp=1", busy); end
    tick();
    tick();
    total += 1;
    if (loading_out_state !== 32'h0D) begin bad++; $display("FAIL done_hold got=%h exp=0000000d", loading_out_state); end
    loading_state = 0;
    tick();
    total += 3;
    if (loading_out_state !== 32'h0) begin bad++; $display("FAIL idle_out got=%h exp=0", loading_out_state); end
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    if (result_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", result_ready); end
  endtask

  task automatic test_dma_error;
    to_wait(pat_3c);
    tick();
    tick();
    dma_error = 1;
    tick();
    dma_error = 0;
    total += 3;
    if (loading_out_state !== 32'hEE) begin bad++; $display("FAIL err_out got=%h exp=000000ee", loading_out_state); end
    if (tx_count !== 32'd1) begin bad++; $display("FAIL err_txcount got=%0d exp=1", tx_count); end
    if (dma_tx_data !== '0) begin bad++; $display("FAIL err_discard got=%h exp=0", dma_tx_data[63:0]); end
    tick();
    loading_state = 0;
    tick();
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL err_idle_busy got=%b exp=0", busy); end
    if (loading_out_state !== 32'h0) begin bad++; $display("FAIL err_idle_out got=%h exp=0", loading_out_state); end
  endtask

  task automatic test_simultaneous;
    to_wait(pat_a5);
    dma_done = 1;
    dma_error = 1;
    tick();
    dma_done = 0;
    dma_error = 0;
    total += 2;
    if (loading_out_state !== 32'hEE) begin bad++; $display("FAIL both_out got=%h exp=000000ee", loading_out_state); end
    if (tx_count !== 32'd1) begin bad++; $display("FAIL both_txcount got=%0d exp=1", tx_count); end
    loading_state = 0;
    tick();
    total += 1;
    if (busy !== 1'b0) begin bad++; $display("FAIL both_idle got=%b exp=0", busy); end
  endtask

  task automatic test_ignore_outside_wait;
    dma_done = 1;
    dma_error = 1;
    tick();
    tick();
    dma_done = 0;
    dma_error = 0;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%b exp=0", busy); end
    if (tx_count !== 32'd1) begin bad++; $display("FAIL ignore_txcount got=%0d exp=1", tx_count); end
    if (loading_out_state !== 32'h0) begin bad++; $display("FAIL ignore_out got=%h exp=0", loading_out_state); end
  endtask

  task automatic test_not_busy;
    int s0;
    s0 = starts;
    dma_idle = 0;
    result = pat_3c;
    result_valid = 1;
    tick();
    result_valid = 0;
    loading_state = 32'h0D;
    for (int i = 0; i < 4; i++) tick();
    total += 2;
    if (starts != s0) begin bad++; $display("FAIL dmabusy_starts got=%0d exp=0", starts - s0); end
    if (dma_tx_start !== 1'b0) begin bad++; $display("FAIL dmabusy_start got=%b exp=0", dma_tx_start); end
    dma_idle = 1;
    tick();
    total += 1;
    if (dma_tx_start !== 1'b1) begin bad++; $display("FAIL dmaidle_start got=%b exp=1", dma_tx_start); end
    tick();
    dma_done = 1;
    tick();
    dma_done = 0;
    total += 3;
    if (tx_count !== 32'd2) begin bad++; $display("FAIL second_txcount got=%0d exp=2", tx_count); end
    if (dma_tx_data !== pat_3c) begin bad++; $display("FAIL second_data got=%h exp=%h", dma_tx_data[63:0], pat_3c[63:0]); end
    if (starts - s0 != 1) begin bad++; $display("FAIL second_starts got=%0d exp=1", starts - s0); end
    loading_state = 0;
    tick();
  endtask

  task automatic test_reset_mid;
    int s0;
    to_wait(pat_a5);
    s0 = starts;
    tick();
    loading_state = 0;
    reset = 1;
    tick();
    reset = 0;
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (tx_count !== 32'd0) begin bad++; $display("FAIL rstmid_txcount got=%0d exp=0", tx_count); end
    if (loading_out_state !== 32'h0) begin bad++; $display("FAIL rstmid_out got=%h exp=0", loading_out_state); end
    if (dma_tx_data !== '0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", dma_tx_data[63:0]); end
    for (int i = 0; i < 3; i++) tick();
    total += 2;
    if (starts != s0) begin bad++; $display("FAIL rstmid_starts got=%0d exp=0", starts - s0); end
    if (result_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", result_ready); end
  endtask

  task automatic test_timeout;
    int n;
    to_wait(pat_one);
    n = 0;
    while (loading_out_state !== 32'hEE && n < 70000) begin
      tick();
      n++;
    end
    total += 3;
    if (n < 65535 || n > 65537) begin bad++; $display("FAIL timeout_cycles got=%0d exp=65536", n); end
    if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy got=%b exp=1", busy); end
    if (tx_count !== 32'd0) begin bad++; $display("FAIL timeout_txcount got=%0d exp=0", tx_count); end
    loading_state = 0;
    tick();
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b exp=0", busy); end
    if (loading_out_state !== 32'h0) begin bad++; $display("FAIL timeout_out got=%h exp=0", loading_out_state); end
  endtask

  initial begin
    pat_a5 = {128{8'hA5}};
    pat_one = 1024'h1;
    pat_3c = {128{8'h3C}};
    test_reset();
    test_nominal();
    test_dma_error();
    test_simultaneous();
    test_ignore_outside_wait();
    test_not_busy();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
